// File: rtl/steer_en_ctrl.sv
// steer_en_ctrl: rider-presence and warning-source controller feeding the
// piezo driver.
//   clk, rst           : clock, synchronous active-high reset
//   lft_ld, rght_ld    : left/right load cells, unsigned 12-bit
//   vbatt              : battery reading, unsigned 12-bit
//   duty               : motor duty, two's complement 12-bit
//   steer_en_tmr_full  : settle timer expired (timer lives in the piezo block)
//   en_steer           : steering enabled
//   rider_off          : no rider present
//   steer_en_clr_tmr   : one-cycle pulse per clear request (stays high if back-to-back)
//   batt_low           : debounced battery-low warning level
//   ovr_spd            : overspeed warning level with hysteresis
// All outputs are flops.
module steer_en_ctrl #(
  parameter logic [11:0] MIN_RIDER_WT  = 12'h200,
  parameter logic [11:0] WT_HYST       = 12'h040,
  parameter logic [11:0] BATT_THRES    = 12'h800,
  parameter logic [11:0] BATT_HYST     = 12'h020,
  parameter int          DB_CNT        = 8,
  parameter logic [11:0] OVR_SPD_THRES = 12'd1536,
  parameter logic [11:0] SPD_HYST      = 12'd64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  input  logic [11:0] vbatt,
  input  logic [11:0] duty,
  input  logic        steer_en_tmr_full,
  output logic        en_steer,
  output logic        rider_off,
  output logic        steer_en_clr_tmr,
  output logic        batt_low,
  output logic        ovr_spd
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, STEER = 2'd2} state_t;

  state_t state, nxt;
  logic   clr_req;

  // ---------------- load-cell arithmetic ----------------
  logic [12:0] sum;
  logic [11:0] diff;
  logic [13:0] diff_x4;
  logic [16:0] diff_x16;
  logic [16:0] sum_x15;
  logic        diff_gt_q, diff_gt_15_16, on, off;

  assign sum      = {1'b0, lft_ld} + {1'b0, rght_ld};
  assign diff     = (lft_ld >= rght_ld) ? (lft_ld - rght_ld) : (rght_ld - lft_ld);
  assign diff_x4  = {diff, 2'b00};
  assign diff_x16 = {1'b0, diff, 4'b0000};
  assign sum_x15  = {4'b0000, sum} * 17'd15;

  assign diff_gt_q     = diff_x4 > {1'b0, sum};
  assign diff_gt_15_16 = diff_x16 > sum_x15;
  // Between the two thresholds neither fires, so the FSM holds.
  assign on  = sum > {1'b0, MIN_RIDER_WT};
  assign off = sum < {1'b0, MIN_RIDER_WT - WT_HYST};

  // ---------------- rider FSM ----------------
  always_comb begin
    nxt     = state;
    clr_req = 1'b0;
    case (state)
      IDLE: begin
        if (on) begin
          nxt     = WAIT;
          clr_req = 1'b1;
        end
      end
      WAIT: begin
        if (off) begin
          nxt = IDLE;
        end else if (diff_gt_q) begin
          // keep the settle timer pinned at zero while unbalanced
          clr_req = 1'b1;
        end else if (steer_en_tmr_full) begin
          nxt = STEER;
        end
      end
      STEER: begin
        if (off) begin
          nxt = IDLE;
        end else if (diff_gt_15_16) begin
          nxt     = WAIT;
          clr_req = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Outputs decoded from the next state so they land in the same cycle as
  // the state update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      en_steer         <= 1'b0;
      rider_off        <= 1'b1;
      steer_en_clr_tmr <= 1'b0;
    end else begin
      state            <= nxt;
      en_steer         <= (nxt == STEER);
      rider_off        <= (nxt == IDLE);
      steer_en_clr_tmr <= clr_req;
    end
  end

  // ---------------- battery-low debounce ----------------
  logic [7:0]  db_cnt;
  logic [12:0] batt_clr_lvl;
  logic        below, above, batt_cond;

  assign batt_clr_lvl = {1'b0, BATT_THRES} + {1'b0, BATT_HYST};
  assign below        = vbatt < BATT_THRES;
  assign above        = {1'b0, vbatt} >= batt_clr_lvl;
  // The condition being debounced is whichever would flip the current level.
  assign batt_cond    = batt_low ? above : below;

  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt   <= 8'd0;
      batt_low <= 1'b0;
    end else if (!batt_cond) begin
      db_cnt <= 8'd0;
    end else if (db_cnt == 8'(DB_CNT - 1)) begin
      batt_low <= ~batt_low;
      db_cnt   <= 8'd0;
    end else if (db_cnt != 8'hFF) begin
      db_cnt <= db_cnt + 8'd1;
    end
  end

  // ---------------- overspeed ----------------
  // Two's-complement negate of -2048 yields 12'h800, which reads as 2048
  // when treated as unsigned: exactly the magnitude wanted.
  logic [11:0] mag;
  assign mag = duty[11] ? (~duty + 12'd1) : duty;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_spd <= 1'b0;
    end else if (mag > OVR_SPD_THRES) begin
      ovr_spd <= 1'b1;
    end else if (mag <= (OVR_SPD_THRES - SPD_HYST)) begin
      ovr_spd <= 1'b0;
    end
  end

endmodule

// File: tb/tb_steer_en_ctrl.sv
// Directed bench for steer_en_ctrl. Inputs change 1 time unit after a
// rising edge; outputs are read 1 time unit after the following edge.
module tb_steer_en_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] lft_ld, rght_ld, vbatt, duty;
  logic        steer_en_tmr_full;
  logic        en_steer, rider_off, steer_en_clr_tmr, batt_low, ovr_spd;

  int n_tests = 0;
  int n_fail  = 0;

  steer_en_ctrl dut (
    .clk(clk), .rst(rst), .lft_ld(lft_ld), .rght_ld(rght_ld), .vbatt(vbatt),
    .duty(duty), .steer_en_tmr_full(steer_en_tmr_full), .en_steer(en_steer),
    .rider_off(rider_off), .steer_en_clr_tmr(steer_en_clr_tmr),
    .batt_low(batt_low), .ovr_spd(ovr_spd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic ld(input logic [11:0] l, input logic [11:0] r);
    lft_ld  = l;
    rght_ld = r;
  endtask

  initial begin
    rst = 1'b1; ld(12'h000, 12'h000); vbatt = 12'hFFF; duty = 12'h000;
    steer_en_tmr_full = 1'b0;
    tick(); tick();
    chk("rst_en", en_steer, 1'b0);
    chk("rst_off", rider_off, 1'b1);
    chk("rst_clr", steer_en_clr_tmr, 1'b0);
    chk("rst_batt", batt_low, 1'b0);
    chk("rst_ovr", ovr_spd, 1'b0);

    // mount
    rst = 1'b0; ld(12'h180, 12'h180);
    tick();
    chk("mount_off", rider_off, 1'b0);
    chk("mount_clr", steer_en_clr_tmr, 1'b1);
    chk("mount_en", en_steer, 1'b0);
    tick();
    chk("mount_clr_1cyc", steer_en_clr_tmr, 1'b0);

    // imbalance while waiting: clear every cycle, tmr_full ignored
    ld(12'h280, 12'h080);
    tick();
    chk("imb_clr0", steer_en_clr_tmr, 1'b1);
    steer_en_tmr_full = 1'b1;
    tick();
    chk("imb_clr1", steer_en_clr_tmr, 1'b1);
    chk("imb_en", en_steer, 1'b0);
    steer_en_tmr_full = 1'b0;
    tick();
    chk("imb_clr2", steer_en_clr_tmr, 1'b1);

    // balance restored, then settle timer expires
    ld(12'h180, 12'h180);
    tick();
    chk("bal_clr", steer_en_clr_tmr, 1'b0);
    chk("bal_en", en_steer, 1'b0);
    steer_en_tmr_full = 1'b1;
    tick();
    chk("steer_en", en_steer, 1'b1);
    steer_en_tmr_full = 1'b0;

    // step-off hysteresis
    ld(12'h0E8, 12'h0E8); // sum 0x1D0, inside band
    tick();
    chk("hyst_hold", en_steer, 1'b1);
    ld(12'h0D8, 12'h0D8); // sum 0x1B0, below band
    tick();
    chk("stepoff_en", en_steer, 1'b0);
    chk("stepoff_off", rider_off, 1'b1);
    steer_en_tmr_full = 1'b1;
    tick();
    chk("idle_tmr_en", en_steer, 1'b0);
    chk("idle_tmr_off", rider_off, 1'b1);
    chk("idle_tmr_clr", steer_en_clr_tmr, 1'b0);
    steer_en_tmr_full = 1'b0;

    // back to STEER, then severe imbalance
    ld(12'h180, 12'h180);
    tick();
    chk("remount_clr", steer_en_clr_tmr, 1'b1);
    steer_en_tmr_full = 1'b1;
    tick();
    chk("resteer_en", en_steer, 1'b1);
    steer_en_tmr_full = 1'b0;
    ld(12'h300, 12'h000);
    tick();
    chk("sev_en", en_steer, 1'b0);
    chk("sev_off", rider_off, 1'b0);
    chk("sev_clr", steer_en_clr_tmr, 1'b1);
    ld(12'h180, 12'h180);
    tick();
    chk("sev_clr_end", steer_en_clr_tmr, 1'b0);
    steer_en_tmr_full = 1'b1;
    tick();
    chk("sev_resteer", en_steer, 1'b1);
    steer_en_tmr_full = 1'b0;

    // battery debounce: 7 below cycles are not enough
    vbatt = 12'h7FF;
    repeat (7) tick();
    chk("batt_7", batt_low, 1'b0);
    vbatt = 12'h900;
    tick();
    chk("batt_break", batt_low, 1'b0);
    vbatt = 12'h7FF;
    repeat (7) tick();
    chk("batt_7b", batt_low, 1'b0);
    tick();
    chk("batt_set", batt_low, 1'b1);
    vbatt = 12'h810;
    repeat (10) tick();
    chk("batt_band", batt_low, 1'b1);
    vbatt = 12'h820;
    repeat (7) tick();
    chk("batt_clr7", batt_low, 1'b1);
    tick();
    chk("batt_clr", batt_low, 1'b0);

    // overspeed
    duty = 12'd1537;
    tick();
    chk("ovr_set", ovr_spd, 1'b1);
    duty = 12'(-1500);
    tick();
    chk("ovr_hold", ovr_spd, 1'b1);
    duty = 12'(-1472);
    tick();
    chk("ovr_clr", ovr_spd, 1'b0);
    duty = 12'd1536;
    tick();
    chk("ovr_thres_eq", ovr_spd, 1'b0);
    duty = 12'h800; // -2048
    tick();
    chk("ovr_min", ovr_spd, 1'b1);

    // get batt_low high, then reset with every warning active
    vbatt = 12'h7FF;
    repeat (8) tick();
    chk("pre_rst_batt", batt_low, 1'b1);
    chk("pre_rst_en", en_steer, 1'b1);
    rst = 1'b1; steer_en_tmr_full = 1'b1;
    tick();
    chk("mid_rst_en", en_steer, 1'b0);
    chk("mid_rst_off", rider_off, 1'b1);
    chk("mid_rst_clr", steer_en_clr_tmr, 1'b0);
    chk("mid_rst_batt", batt_low, 1'b0);
    chk("mid_rst_ovr", ovr_spd, 1'b0);
    // counter must restart from zero after reset
    rst = 1'b0; steer_en_tmr_full = 1'b0; duty = 12'h000;
    repeat (7) tick();
    chk("post_rst_batt7", batt_low, 1'b0);
    tick();
    chk("post_rst_batt8", batt_low, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/steer_en_ctrl.md
Name: steer_en_ctrl

Overview:
- Rider-presence and warning-source controller directly upstream of the piezo driver.
- Derives en_steer and the steering-timer clear pulse from left/right load-cell readings, using the piezo block's steer_en_tmr_full as its settle timer.
- Generates the batt_low and ovr_spd warning levels that the piezo driver turns into tones.
- All outputs are registered.

Parameters:
MIN_RIDER_WT, 12'h200, load sum above which a rider is considered present
WT_HYST, 12'h040, hysteresis; rider leaves when sum < MIN_RIDER_WT - WT_HYST
BATT_THRES, 12'h800, battery reading below which the battery is low
BATT_HYST, 12'h020, battery clears when vbatt >= BATT_THRES + BATT_HYST
DB_CNT, 8, consecutive cycles a battery condition must hold before batt_low changes (1..255)
OVR_SPD_THRES, 12'd1536, duty magnitude above which overspeed asserts
SPD_HYST, 12'd64, overspeed clears when magnitude <= OVR_SPD_THRES - SPD_HYST

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
lft_ld  in  12  left load cell, unsigned
rght_ld  in  12  right load cell, unsigned
vbatt  in  12  battery reading, unsigned
duty  in  12  motor duty, two's complement
steer_en_tmr_full  in  1  settle timer expired (from piezo block)
en_steer  out  1  steering enabled
rider_off  out  1  no rider present
steer_en_clr_tmr  out  1  one-cycle pulse that clears the settle timer
batt_low  out  1  battery-low warning level
ovr_spd  out  1  overspeed warning level

Behaviour:
- Reset: sampled on posedge clk while rst=1.
  - State goes to IDLE.
  - en_steer=0, rider_off=1, steer_en_clr_tmr=0, batt_low=0, ovr_spd=0.
  - Debounce counter is cleared.
  - Reset mid-operation overrides all other conditions in that cycle.
- Arithmetic:
  - sum = lft_ld + rght_ld, 13 bits, no overflow.
  - diff = |lft_ld - rght_ld|, 12 bits.
  - diff_gt_q = 4*diff > sum.
  - diff_gt_15_16 = 16*diff > 15*sum, evaluated at 17 bits.
  - on = sum > MIN_RIDER_WT; off = sum < MIN_RIDER_WT - WT_HYST. Values between the two hold the current state.
- FSM (conditions checked in the order listed):
  - IDLE: on -> WAIT and request clear.
  - WAIT:
    - off -> IDLE.
    - else diff_gt_q -> stay and request clear.
    - else steer_en_tmr_full -> STEER.
  - STEER:
    - off -> IDLE.
    - else diff_gt_15_16 -> WAIT and request clear.
- FSM outputs:
  - en_steer = (state==STEER); rider_off = (state==IDLE). Both are registered with the state, so they change the cycle after the deciding input is sampled.
  - steer_en_clr_tmr is a registered copy of the clear request: high exactly in the cycle after each request. Consecutive requests keep it high.
  - steer_en_tmr_full while in IDLE, or together with off, is ignored.
- batt_low:
  - Condition below = vbatt < BATT_THRES; condition above = vbatt >= BATT_THRES + BATT_HYST.
  - When batt_low=0: the counter increments on each below cycle and clears on any other cycle. batt_low sets when the counter reaches DB_CNT-1 with below still true, i.e. on the DB_CNT-th consecutive below cycle, visible the next cycle. The counter then clears.
  - When batt_low=1: the same rule applies using the above condition.
  - The counter is 8 bits and saturates.
- ovr_spd:
  - mag = |duty|, 12-bit unsigned; -2048 gives 2048.
  - ovr_spd sets the cycle after mag > OVR_SPD_THRES.
  - ovr_spd clears the cycle after mag <= OVR_SPD_THRES - SPD_HYST; otherwise it holds.
  - No debounce; independent of the FSM.

Test Plan:
- Rider mount: rst 2 cycles, then lft=rght=0x180 (sum 0x300) -> next cycle rider_off=0, clr_tmr=1 for exactly 1 cycle. Pulse steer_en_tmr_full at cycle 10 -> en_steer=1 at cycle 11.
- Imbalance while waiting: WAIT with lft=0x280, rght=0x080 (4*diff=0x800 > 0x300) -> clr_tmr high every cycle while applied; a tmr_full pulse is ignored and en_steer stays 0.
- Step-off hysteresis: in STEER, sum=0x1D0 -> still STEER. sum=0x1B0 -> next cycle en_steer=0, rider_off=1. Any tmr_full afterwards -> no change.
- Severe imbalance: in STEER, lft=0x300, rght=0x000 -> WAIT, en_steer=0, one clr_tmr pulse. Restoring balance then tmr_full -> STEER again.
- Battery debounce: vbatt=0x7FF for 7 cycles then 0x900 -> batt_low stays 0. vbatt=0x7FF for 8 cycles -> batt_low=1 on the 9th cycle. vbatt=0x810 -> stays 1. vbatt=0x820 for 8 cycles -> batt_low=0.
- Overspeed: duty=12'sd1537 -> ovr_spd=1 next cycle. duty=-1500 -> holds 1. duty=-1472 -> clears. duty=-2048 -> sets. rst mid-warning -> all outputs return to reset values next cycle.
